pipeline_stall_controller: RTL and testbench
============================================

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, range 1..3: number of consecutive cycles IF/ID is flushed per taken branch.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, range 1..255: maximum MEM_WAIT cycles before timeout.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Stall  in  1  load-use hazard request.
- Flush  in  1  branch-taken flush request.
- MemAccess  in  1  MEM stage holds a load/store.
- MemReady  in  1  data memory completes the access this cycle.
- CountClear  in  1  synchronous clear of the performance counters.
- PCWrite, IF_ID_Write  out  1  write enables for PC and IF/ID.
- IF_ID_Flush, ID_EX_Flush  out  1  bubble insertion into IF/ID and ID/EX.
- EX_MEM_Write, MEM_WB_Write  out  1  write enables for EX/MEM and MEM/WB.
- MemTimeout  out  1  one-cycle pulse on a memory wait timeout.
- State  out  2  RUN=0, FLUSH=1, MEM_WAIT=2.
- StallCount, FlushCount, MemWaitCount  out  16  performance counters.

Function
REQ-004 Control outputs SHALL be combinational (Mealy) from the current state and inputs; State, the counters and MemTimeout SHALL be registered.
REQ-005 Evaluation priority each cycle SHALL be: memory wait > Stall > pending/new flush > normal.
REQ-006 Normal: all write enables SHALL be 1 and both flushes 0.
REQ-007 Memory wait condition: (MemAccess and not MemReady) in RUN/FLUSH, or not MemReady in MEM_WAIT. All write enables SHALL be 0 and both flushes 0. Next state SHALL be MEM_WAIT.
REQ-008 Stall (no memory wait): PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0, other enables 1. Flush SHALL be ignored that cycle. No state change. StallCount SHALL increment.
REQ-009 Flush in RUN (no memory wait, no Stall): IF_ID_Flush=1, all enables 1. FlushCount SHALL increment. The pending count SHALL be loaded with FLUSH_CYCLES-1. Next state SHALL be FLUSH if that value is >0, else RUN.
REQ-010 FLUSH state (no memory wait, no Stall): IF_ID_Flush=1, all enables 1, pending decrements. The state SHALL return to RUN when pending reaches 0. A new Flush here SHALL reload pending with FLUSH_CYCLES-1 and increment FlushCount.
REQ-011 Stall in FLUSH state SHALL apply REQ-008 outputs and hold pending unchanged.
REQ-012 Entry into MEM_WAIT SHALL preserve pending. An 8-bit wait counter SHALL clear on entry and increment each MEM_WAIT cycle. MemWaitCount SHALL increment each MEM_WAIT cycle.
REQ-013 MemReady=1 in MEM_WAIT: that cycle SHALL be evaluated as FLUSH if pending>0, else as RUN (REQ-008..010 apply). The next state SHALL follow from that evaluation.
REQ-014 Wait counter reaching MEM_TIMEOUT with MemReady=0: MemTimeout=1 for exactly that cycle, outputs frozen per REQ-007, pending cleared, next state RUN.
REQ-015 Counters SHALL saturate at 16'hFFFF. CountClear SHALL zero all three and take priority over same-cycle increments.

Reset
REQ-016 reset low SHALL asynchronously force State=RUN, pending=0, wait counter=0, MemTimeout=0, and all counters=0. Control outputs SHALL equal the RUN-state evaluation of the inputs.
REQ-017 Reset asserted mid-FLUSH or mid-MEM_WAIT SHALL abandon the sequence. No pulse SHALL be produced on reset release.

Verification
REQ-018 Stall=1 for one cycle, idle otherwise -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 that cycle; StallCount=1; State stays 0.
REQ-019 FLUSH_CYCLES=3, Flush pulse -> IF_ID_Flush=1 for 3 consecutive cycles, State 0,1,1,0; FlushCount=1.
REQ-020 Stall=1 and Flush=1 together -> stall outputs only, IF_ID_Flush=0; next cycle Stall=0, Flush=1 -> flush applied; StallCount=1, FlushCount=1.
REQ-021 MemAccess=1, MemReady=0 for 4 cycles then MemReady=1 -> all enables 0 for 4 cycles, State=2; release cycle normal; MemWaitCount=3 (entry cycle in RUN not counted).
REQ-022 MEM_TIMEOUT=5, MemReady held 0 -> MemTimeout=1 on the 5th MEM_WAIT cycle, then State=0.
REQ-023 FLUSH_CYCLES=3, memory wait begins in the 2nd flush cycle and is followed by MemReady -> the remaining flush cycle is delivered after release; reset low mid-wait -> State=0 and counters=0 immediately.

Source files
------------

// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the hazard unit/memory side and the stall
// controller. The slave side is the controller; the master side is whatever
// drives hazard requests and consumes the pipeline register enables.
interface pipeline_stall_controller_if;
  // hazard and memory status inputs to the controller
  logic        Stall;
  logic        Flush;
  logic        MemAccess;
  logic        MemReady;
  logic        CountClear;

  // pipeline register control (combinational from the controller)
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Flush;
  logic        EX_MEM_Write;
  logic        MEM_WB_Write;

  // registered status
  logic        MemTimeout;
  logic [1:0]  State;
  logic [15:0] StallCount;
  logic [15:0] FlushCount;
  logic [15:0] MemWaitCount;

  modport master (
    output Stall, Flush, MemAccess, MemReady, CountClear,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
    input  EX_MEM_Write, MEM_WB_Write,
    input  MemTimeout, State, StallCount, FlushCount, MemWaitCount
  );

  modport slave (
    input  Stall, Flush, MemAccess, MemReady, CountClear,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
    output EX_MEM_Write, MEM_WB_Write,
    output MemTimeout, State, StallCount, FlushCount, MemWaitCount
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller for a 5-stage pipe.
// Priority each cycle: memory wait > load-use stall > flush > normal.
// A taken branch bubbles IF/ID for FLUSH_CYCLES cycles; a stalled memory
// access freezes the whole pipe, remembering any unfinished flush so it is
// delivered once memory releases. Enables are Mealy; State, counters and
// MemTimeout are registered.
module pipeline_stall_controller #(
  parameter int FLUSH_CYCLES = 1,   // 1..3
  parameter int MEM_TIMEOUT  = 255  // 1..255
) (
  input logic                      clk,
  input logic                      reset,   // async, active low
  pipeline_stall_controller_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [8:0] TIMEOUT_LIM  = 9'(MEM_TIMEOUT);
  localparam logic [15:0] CNT_MAX     = 16'hFFFF;

  state_t      state_q, state_d;
  state_t      eff_st;       // state the non-wait evaluation behaves as
  logic [1:0]  pend_q, pend_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        tmo_q, tmo_d;
  logic        mem_wait;
  logic        inc_stall, inc_flush, inc_mwait;
  logic [15:0] stall_cnt_q, flush_cnt_q, mwait_cnt_q;

  logic        pc_wr, ifid_wr, ifid_fl, idex_fl, exmem_wr, memwb_wr;

  // state, pending flush count, wait counter and timeout pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pend_q  <= '0;
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // next-state and Mealy control outputs
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    wcnt_d    = wcnt_q;
    tmo_d     = 1'b0;
    inc_stall = 1'b0;
    inc_flush = 1'b0;
    inc_mwait = 1'b0;
    pc_wr     = 1'b1;
    ifid_wr   = 1'b1;
    ifid_fl   = 1'b0;
    idex_fl   = 1'b0;
    exmem_wr  = 1'b1;
    memwb_wr  = 1'b1;

    // In MEM_WAIT only MemReady matters; elsewhere a wait starts when an
    // access is present and memory is not ready.
    if (state_q == MEM_WAIT) mem_wait = ~bus.MemReady;
    else                     mem_wait = bus.MemAccess & ~bus.MemReady;

    // On release from MEM_WAIT the cycle behaves like the state that was
    // interrupted, recovered from whether a flush is still owed.
    if (state_q == MEM_WAIT) eff_st = (pend_q != 2'd0) ? FLUSH : RUN;
    else                     eff_st = state_q;

    if (mem_wait) begin
      pc_wr    = 1'b0;
      ifid_wr  = 1'b0;
      exmem_wr = 1'b0;
      memwb_wr = 1'b0;
      if (state_q == MEM_WAIT) begin
        inc_mwait = 1'b1;
        if (({1'b0, wcnt_q} + 9'd1) >= TIMEOUT_LIM) begin
          // give up on the access: drop any owed flush and resume
          tmo_d   = 1'b1;
          pend_d  = '0;
          wcnt_d  = '0;
          state_d = RUN;
        end else begin
          wcnt_d  = wcnt_q + 8'd1;
          state_d = MEM_WAIT;
        end
      end else begin
        // entry cycle: pending flush count is kept as-is
        wcnt_d  = '0;
        state_d = MEM_WAIT;
      end
    end else if (bus.Stall) begin
      // load-use bubble; a same-cycle Flush is dropped and pending held
      pc_wr     = 1'b0;
      ifid_wr   = 1'b0;
      idex_fl   = 1'b1;
      inc_stall = 1'b1;
      state_d   = eff_st;
    end else if (bus.Flush) begin
      // new branch (also re-arms an in-progress flush sequence)
      ifid_fl   = 1'b1;
      inc_flush = 1'b1;
      pend_d    = FLUSH_RELOAD;
      state_d   = (FLUSH_RELOAD != 2'd0) ? FLUSH : RUN;
    end else if (eff_st == FLUSH) begin
      ifid_fl   = 1'b1;
      pend_d    = pend_q - 2'd1;
      state_d   = (pend_q > 2'd1) ? FLUSH : RUN;
    end else begin
      state_d   = RUN;
    end
  end

  // saturating performance counters, clear wins over increments
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mwait_cnt_q <= '0;
    end else if (bus.CountClear) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mwait_cnt_q <= '0;
    end else begin
      if (inc_stall && stall_cnt_q != CNT_MAX) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (inc_flush && flush_cnt_q != CNT_MAX) flush_cnt_q <= flush_cnt_q + 16'd1;
      if (inc_mwait && mwait_cnt_q != CNT_MAX) mwait_cnt_q <= mwait_cnt_q + 16'd1;
    end
  end

  assign bus.PCWrite      = pc_wr;
  assign bus.IF_ID_Write  = ifid_wr;
  assign bus.IF_ID_Flush  = ifid_fl;
  assign bus.ID_EX_Flush  = idex_fl;
  assign bus.EX_MEM_Write = exmem_wr;
  assign bus.MEM_WB_Write = memwb_wr;
  assign bus.MemTimeout   = tmo_q;
  assign bus.State        = state_q;
  assign bus.StallCount   = stall_cnt_q;
  assign bus.FlushCount   = flush_cnt_q;
  assign bus.MemWaitCount = mwait_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (FLUSH_CYCLES=3, MEM_TIMEOUT=5).
// Stimulus pushes the hand-computed expected observation of each cycle into
// a queue; a negedge monitor pops and compares it against the DUT.
module tb_pipeline_stall_controller;

  // control bits: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, MEM_WB_Write}
  localparam logic [5:0] NORM = 6'b110011;
  localparam logic [5:0] STL  = 6'b000111;
  localparam logic [5:0] FLS  = 6'b111011;
  localparam logic [5:0] FRZ  = 6'b000000;

  typedef struct packed {
    logic [5:0]  ctrl;
    logic        tmo;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
    logic [15:0] mwc;
  } obs_t;

  logic clk;
  logic reset;
  obs_t sb_q[$];
  int   n_cmp;
  int   n_bad;

  pipeline_stall_controller_if bus();

  pipeline_stall_controller #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one cycle of stimulus plus the observation expected mid-cycle
  task automatic step(input logic r, input logic s, input logic f,
                      input logic ma, input logic mr, input logic cc,
                      input logic [5:0] ctrl, input logic tmo, input logic [1:0] st,
                      input logic [15:0] sc, input logic [15:0] fc, input logic [15:0] mwc);
    obs_t e;
    @(posedge clk); #1;
    reset          = r;
    bus.Stall      = s;
    bus.Flush      = f;
    bus.MemAccess  = ma;
    bus.MemReady   = mr;
    bus.CountClear = cc;
    e.ctrl = ctrl; e.tmo = tmo; e.st = st; e.sc = sc; e.fc = fc; e.mwc = mwc;
    sb_q.push_back(e);
  endtask

  // monitor: the DUT presents a full observation every cycle
  always @(negedge clk) begin
    obs_t e, a;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a.ctrl = {bus.PCWrite, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Flush,
                bus.EX_MEM_Write, bus.MEM_WB_Write};
      a.tmo = bus.MemTimeout;
      a.st  = bus.State;
      a.sc  = bus.StallCount;
      a.fc  = bus.FlushCount;
      a.mwc = bus.MemWaitCount;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cmp#%0d: got ctrl=%b tmo=%b st=%0d sc=%0d fc=%0d mwc=%0d, want ctrl=%b tmo=%b st=%0d sc=%0d fc=%0d mwc=%0d",
                 n_cmp, a.ctrl, a.tmo, a.st, a.sc, a.fc, a.mwc,
                 e.ctrl, e.tmo, e.st, e.sc, e.fc, e.mwc);
      end
    end
  end

  initial begin
    int guard;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    bus.Stall = 1'b0; bus.Flush = 1'b0; bus.MemAccess = 1'b0;
    bus.MemReady = 1'b0; bus.CountClear = 1'b0;

    //   r  s  f  ma mr cc  ctrl  tmo st   sc  fc  mwc
    // reset and release
    step(0, 0, 0, 0, 0, 0, NORM, 0, 0,  0, 0, 0);
    step(1, 0, 0, 0, 0, 0, NORM, 0, 0,  0, 0, 0);
    // single stall
    step(1, 1, 0, 0, 0, 0, STL,  0, 0,  0, 0, 0);
    step(1, 0, 0, 0, 0, 0, NORM, 0, 0,  1, 0, 0);
    // stall wins over flush, then the flush runs 3 cycles
    step(1, 1, 1, 0, 0, 0, STL,  0, 0,  1, 0, 0);
    step(1, 0, 1, 0, 0, 0, FLS,  0, 0,  2, 0, 0);
    step(1, 0, 0, 0, 0, 0, FLS,  0, 1,  2, 1, 0);
    step(1, 0, 0, 0, 0, 0, FLS,  0, 1,  2, 1, 0);
    step(1, 0, 0, 0, 0, 0, NORM, 0, 0,  2, 1, 0);
    // isolated flush pulse: State 0,1,1,0
    step(1, 0, 1, 0, 0, 0, FLS,  0, 0,  2, 1, 0);
    step(1, 0, 0, 0, 0, 0, FLS,  0, 1,  2, 2, 0);
    step(1, 0, 0, 0, 0, 0, FLS,  0, 1,  2, 2, 0);
    step(1, 0, 0, 0, 0, 0, NORM, 0, 0,  2, 2, 0);
    // stall inside FLUSH holds the pending count
    step(1, 0, 1, 0, 0, 0, FLS,  0, 0,  2, 2, 0);
    step(1, 1, 0, 0, 0, 0, STL,  0, 1,  2, 3, 0);
    step(1, 0, 0, 0, 0, 0, FLS,  0, 1,  3, 3, 0);
    step(1, 0, 0, 0, 0, 0, FLS,  0, 1,  3, 3, 0);
    step(1, 0, 0, 0, 0, 0, NORM, 0, 0,  3, 3, 0);
    // new flush inside FLUSH re-arms the sequence
    step(1, 0, 1, 0, 0, 0, FLS,  0, 0,  3, 3, 0);
    step(1, 0, 1, 0, 0, 0, FLS,  0, 1,  3, 4, 0);
    step(1, 0, 0, 0, 0, 0, FLS,  0, 1,  3, 5, 0);
    step(1, 0, 0, 0, 0, 0, FLS,  0, 1,  3, 5, 0);
    step(1, 0, 0, 0, 0, 0, NORM, 0, 0,  3, 5, 0);
    // memory wait 4 cycles then release
    step(1, 0, 0, 1, 0, 0, FRZ,  0, 0,  3, 5, 0);
    step(1, 0, 0, 1, 0, 0, FRZ,  0, 2,  3, 5, 0);
    step(1, 0, 0, 1, 0, 0, FRZ,  0, 2,  3, 5, 1);
    step(1, 0, 0, 1, 0, 0, FRZ,  0, 2,  3, 5, 2);
    step(1, 0, 0, 1, 1, 0, NORM, 0, 2,  3, 5, 3);
    step(1, 0, 0, 0, 0, 0, NORM, 0, 0,  3, 5, 3);
    // timeout on the 5th MEM_WAIT cycle; registered pulse follows with State=0
    step(1, 0, 0, 1, 0, 0, FRZ,  0, 0,  3, 5, 3);
    step(1, 0, 0, 1, 0, 0, FRZ,  0, 2,  3, 5, 3);
    step(1, 0, 0, 1, 0, 0, FRZ,  0, 2,  3, 5, 4);
    step(1, 0, 0, 1, 0, 0, FRZ,  0, 2,  3, 5, 5);
    step(1, 0, 0, 1, 0, 0, FRZ,  0, 2,  3, 5, 6);
    step(1, 0, 0, 1, 0, 0, FRZ,  0, 2,  3, 5, 7);
    step(1, 0, 0, 0, 0, 0, NORM, 1, 0,  3, 5, 8);
    step(1, 0, 0, 0, 0, 0, NORM, 0, 0,  3, 5, 8);
    // wait starts in the 2nd flush cycle; owed flush cycles follow release
    step(1, 0, 1, 0, 0, 0, FLS,  0, 0,  3, 5, 8);
    step(1, 0, 0, 1, 0, 0, FRZ,  0, 1,  3, 6, 8);
    step(1, 0, 0, 1, 0, 0, FRZ,  0, 2,  3, 6, 8);
    step(1, 0, 0, 1, 1, 0, FLS,  0, 2,  3, 6, 9);
    step(1, 0, 0, 0, 0, 0, FLS,  0, 1,  3, 6, 9);
    step(1, 0, 0, 0, 0, 0, NORM, 0, 0,  3, 6, 9);
    // reset mid-wait: immediate, outputs follow RUN evaluation
    step(1, 0, 0, 1, 0, 0, FRZ,  0, 0,  3, 6, 9);
    step(1, 0, 0, 1, 0, 0, FRZ,  0, 2,  3, 6, 9);
    step(0, 0, 0, 1, 0, 0, FRZ,  0, 0,  0, 0, 0);
    step(1, 0, 0, 0, 0, 0, NORM, 0, 0,  0, 0, 0);
    step(1, 0, 0, 0, 0, 0, NORM, 0, 0,  0, 0, 0);
    // reset mid-flush abandons the sequence
    step(1, 0, 1, 0, 0, 0, FLS,  0, 0,  0, 0, 0);
    step(0, 0, 0, 0, 0, 0, NORM, 0, 0,  0, 0, 0);
    step(1, 0, 0, 0, 0, 0, NORM, 0, 0,  0, 0, 0);
    // CountClear beats a same-cycle increment
    step(1, 1, 0, 0, 0, 1, STL,  0, 0,  0, 0, 0);
    step(1, 1, 0, 0, 0, 0, STL,  0, 0,  0, 0, 0);
    step(1, 0, 0, 0, 0, 1, NORM, 0, 0,  1, 0, 0);
    step(1, 0, 0, 0, 0, 0, NORM, 0, 0,  0, 0, 0);

    // drive StallCount past its limit without per-cycle expectations
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk); #1;
      bus.Stall = 1'b1; bus.Flush = 1'b0; bus.MemAccess = 1'b0;
      bus.MemReady = 1'b0; bus.CountClear = 1'b0;
    end
    step(1, 1, 0, 0, 0, 0, STL,  0, 0, 16'hFFFF, 0, 0);
    step(1, 0, 0, 0, 0, 0, NORM, 0, 0, 16'hFFFF, 0, 0);

    // let the monitor drain the scoreboard, bounded
    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (sb_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d observations left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
